// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN weight-load path: sizes, bus bit layout,
// the core's power-on weight image and the transmitter FSM states.
package bnn_pkg;

  localparam int NUM_NEURONS   = 12;
  localparam int PTR_WRAP      = 32;
  localparam int ADDR_W        = 4;
  localparam int RESET_ENTRIES = 12;

  localparam int NIB_MSB     = 7;
  localparam int NIB_LSB     = 4;
  localparam int LOAD_EN_BIT = 3;

  // Entry i lives in bits [8*i +: 8]; entry 0 is the rightmost byte.
  localparam logic [8*RESET_ENTRIES-1:0] RESET_IMAGE =
    96'hC0_30_0C_03_00_FF_07_0E_1C_38_70_E0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_LO = 3'd1,
    SEND_HI = 3'd2,
    PAD_LO  = 3'd3,
    PAD_HI  = 3'd4,
    FINISH  = 3'd5
  } tx_state_e;

  function automatic logic [7:0] reset_weight(input int idx);
    if (idx >= 0 && idx < RESET_ENTRIES) return RESET_IMAGE[idx*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] bus_word(input logic [3:0] nib, input logic load);
    logic [7:0] w;
    w = '0;
    w[NIB_MSB:NIB_LSB] = nib;
    w[LOAD_EN_BIT]     = load;
    return w;
  endfunction

endpackage

// File: rtl/bnn_weight_tx_if.sv
// Host-side control, buffer-write and weight-bus signals of bnn_weight_tx.
interface bnn_weight_tx_if;
  import bnn_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              wr_drop;
  logic [7:0]        tx_uio;
  logic [7:0]        tx_oe;

  modport master (
    output wr_en, wr_addr, wr_data, start, hold,
    input  busy, done, wr_drop, tx_uio, tx_oe
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, hold,
    output busy, done, wr_drop, tx_uio, tx_oe
  );

endinterface

// File: rtl/bnn_weight_buf.sv
// Local weight image: one byte per neuron, reset to the core's power-on set,
// with a write-through read so a same-cycle write is visible immediately.
module bnn_weight_buf #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [bnn_pkg::ADDR_W-1:0] waddr,
  input  logic [7:0]                wdata,
  input  logic [bnn_pkg::ADDR_W-1:0] raddr,
  output logic [7:0]                rdata
);
  import bnn_pkg::*;

  logic [7:0] mem [NUM_NEURONS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= reset_weight(i);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (we && (waddr == raddr)) rdata = wdata;
    else if (int'(raddr) < NUM_NEURONS) rdata = mem[raddr];
  end

endmodule

// File: rtl/bnn_weight_tx.sv
// Streams the local weight image onto the BNN weight bus as low/high nibble
// load pairs, optionally padding until the core's neuron pointer wraps.
module bnn_weight_tx #(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int PTR_WRAP    = bnn_pkg::PTR_WRAP,
  parameter bit PAD_EN      = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bnn_weight_tx_if.slave  bus
);
  import bnn_pkg::*;

  localparam int CNT_W  = $clog2(PTR_WRAP);
  localparam bit DO_PAD = PAD_EN && (NUM_NEURONS < PTR_WRAP);

  tx_state_e         st, st_n, est;
  logic [CNT_W-1:0]  cnt, cnt_n, ecnt;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic              drop_r;
  logic [7:0]        uio_r, uio_n;
  logic              wr_ok;
  logic [7:0]        rd_data;

  assign wr_ok = bus.wr_en && (st == IDLE) && (int'(bus.wr_addr) < NUM_NEURONS);

  bnn_weight_buf #(.NUM_NEURONS(NUM_NEURONS)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (ecnt[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  // A start in IDLE is folded into SEND_LO so the first load leaves on the next cycle.
  always_comb begin
    est = st;
    ecnt = cnt;
    if (st == IDLE && bus.start) begin
      est  = SEND_LO;
      ecnt = '0;
    end
    st_n   = est;
    cnt_n  = ecnt;
    busy_n = 1'b1;
    done_n = 1'b0;
    uio_n  = uio_r;
    if (est == IDLE) begin
      busy_n = 1'b0;
    end else if (bus.hold) begin
      uio_n = bus_word(uio_r[NIB_MSB:NIB_LSB], 1'b0);
    end else begin
      unique case (est)
        SEND_LO: begin
          uio_n = bus_word(rd_data[3:0], 1'b1);
          st_n  = SEND_HI;
        end
        SEND_HI: begin
          uio_n = bus_word(rd_data[7:4], 1'b1);
          if (ecnt == CNT_W'(NUM_NEURONS - 1)) begin
            st_n  = DO_PAD ? PAD_LO : FINISH;
            cnt_n = DO_PAD ? ecnt + 1'b1 : ecnt;
          end else begin
            st_n  = SEND_LO;
            cnt_n = ecnt + 1'b1;
          end
        end
        PAD_LO: begin
          uio_n = bus_word(4'h0, 1'b1);
          st_n  = PAD_HI;
        end
        PAD_HI: begin
          uio_n = bus_word(4'h0, 1'b1);
          if (ecnt == CNT_W'(PTR_WRAP - 1)) begin
            st_n = FINISH;
          end else begin
            st_n  = PAD_LO;
            cnt_n = ecnt + 1'b1;
          end
        end
        FINISH: begin
          busy_n = 1'b0;
          done_n = 1'b1;
          uio_n  = '0;
          st_n   = IDLE;
          cnt_n  = '0;
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      drop_r <= 1'b0;
      uio_r  <= '0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      busy_r <= busy_n;
      done_r <= done_n;
      drop_r <= bus.wr_en && !wr_ok;
      uio_r  <= uio_n;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wr_drop = drop_r;
  assign bus.tx_uio  = uio_r;
  assign bus.tx_oe   = busy_r ? 8'hF8 : 8'h00;

endmodule
